// File: rtl/load_store_unit_if.sv
// Execute-side request/response and data-memory handshake for the load/store unit.
interface load_store_unit_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic             is_store;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] store_data;
    logic             busy;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [3:0]       mem_byte_en;
    logic [WIDTH-1:0] mem_wr_data;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rd_data;
    logic             done;
    logic [WIDTH-1:0] load_data;
    logic             misaligned;
    logic             fault;

    modport master (
        output req_valid, is_store, funct3, addr, store_data, mem_ack, mem_rd_data,
        input  busy, mem_req, mem_we, mem_addr, mem_byte_en, mem_wr_data,
               done, load_data, misaligned, fault
    );

    modport slave (
        input  req_valid, is_store, funct3, addr, store_data, mem_ack, mem_rd_data,
        output busy, mem_req, mem_we, mem_addr, mem_byte_en, mem_wr_data,
               done, load_data, misaligned, fault
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one outstanding word-wide access, extended load data or fault to writeback.
// state  | meaning
// IDLE   | waiting for a request; ACCESS | mem_req held until ack/timeout; RESP | one-cycle done
module load_store_unit #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);
    localparam int TO_WIDTH = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state, state_nx;
    logic               req_store;
    logic [2:0]         req_f3;
    logic [WIDTH-1:0]   req_addr;
    logic [WIDTH-1:0]   req_data;
    logic [WIDTH-1:0]   load_q;
    logic               flag_mis;
    logic               flag_fault;
    logic [TO_WIDTH-1:0] to_cnt;

    logic               in_illegal;
    logic               in_mis;
    logic               timed_out;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [WIDTH-1:0]   rd_ext;
    logic [3:0]         lane_en;
    logic [WIDTH-1:0]   lane_data;

    // Request decode works on the raw inputs so a bad request can skip ACCESS.
    always_comb begin
        if (bus.is_store)
            in_illegal = bus.funct3[2] || (bus.funct3[1:0] == 2'b11);
        else
            in_illegal = (bus.funct3[1:0] == 2'b11) || (bus.funct3 == 3'b110);
        in_mis = !in_illegal &&
                 (((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                  ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00)));
    end

    assign timed_out = (to_cnt == TO_WIDTH'(TIMEOUT));

    always_comb begin
        case (req_addr[1:0])
            2'd0:    rd_byte = bus.mem_rd_data[7:0];
            2'd1:    rd_byte = bus.mem_rd_data[15:8];
            2'd2:    rd_byte = bus.mem_rd_data[23:16];
            default: rd_byte = bus.mem_rd_data[31:24];
        endcase
        rd_half = req_addr[1] ? bus.mem_rd_data[31:16] : bus.mem_rd_data[15:0];
        case (req_f3)
            3'b000:  rd_ext = {{(WIDTH-8){rd_byte[7]}}, rd_byte};
            3'b001:  rd_ext = {{(WIDTH-16){rd_half[15]}}, rd_half};
            3'b100:  rd_ext = {{(WIDTH-8){1'b0}}, rd_byte};
            3'b101:  rd_ext = {{(WIDTH-16){1'b0}}, rd_half};
            default: rd_ext = bus.mem_rd_data;
        endcase
    end

    always_comb begin
        case (req_f3[1:0])
            2'b00: begin
                lane_en   = 4'b0001 << req_addr[1:0];
                lane_data = {4{req_data[7:0]}};
            end
            2'b01: begin
                lane_en   = 4'b0011 << req_addr[1:0];
                lane_data = {2{req_data[15:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                lane_data = req_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nx = (in_illegal || in_mis) ? RESP : ACCESS;
            ACCESS:  if (bus.mem_ack || timed_out) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            req_store  <= 1'b0;
            req_f3     <= 3'b000;
            req_addr   <= '0;
            req_data   <= '0;
            load_q     <= '0;
            flag_mis   <= 1'b0;
            flag_fault <= 1'b0;
            to_cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    req_store  <= bus.is_store;
                    req_f3     <= bus.funct3;
                    req_addr   <= bus.addr;
                    req_data   <= bus.store_data;
                    flag_mis   <= in_mis;
                    flag_fault <= in_illegal;
                    load_q     <= '0;
                    to_cnt     <= '0;
                end
                ACCESS: begin
                    // An ack on the final timeout cycle still completes normally.
                    if (bus.mem_ack) begin
                        if (!req_store) load_q <= rd_ext;
                    end else if (timed_out) begin
                        flag_fault <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    flag_mis   <= 1'b0;
                    flag_fault <= 1'b0;
                    load_q     <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy        = (state != IDLE);
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_byte_en = 4'b0000;
        bus.mem_wr_data = '0;
        bus.done        = 1'b0;
        bus.load_data   = '0;
        bus.misaligned  = 1'b0;
        bus.fault       = 1'b0;
        case (state)
            ACCESS: begin
                bus.mem_req     = 1'b1;
                bus.mem_we      = req_store;
                bus.mem_addr    = {req_addr[WIDTH-1:2], 2'b00};
                bus.mem_byte_en = lane_en;
                bus.mem_wr_data = lane_data;
            end
            RESP: begin
                bus.done       = 1'b1;
                bus.load_data  = load_q;
                bus.misaligned = flag_mis;
                bus.fault      = flag_fault;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected responses queued at issue, checked at done.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] ld;
        logic        mis;
        logic        flt;
    } resp_t;

    resp_t sb[$];

    load_store_unit_if #(.WIDTH(32)) bus ();

    load_store_unit #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input string tag, input int n, input bit spur_ack);
        bus.mem_ack = spur_ack;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, ".idle_done"}, bus.done, 1'b0);
            chk({tag, ".idle_req"}, bus.mem_req, 1'b0);
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           input int ack_at, input logic [31:0] rd,
                           input logic e_we, input logic [31:0] e_addr, input logic [3:0] e_ben,
                           input logic [31:0] e_wd, input logic [31:0] e_ld,
                           input logic e_mis, input logic e_flt,
                           input int e_lat, input int e_nreq, input int poke_at);
        resp_t r;
        int    cyc;
        int    nreq;
        bit    got;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.is_store   = st;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.store_data = d;
        sb.push_back('{ld: e_ld, mis: e_mis, flt: e_flt});
        @(negedge clk);
        bus.req_valid = 1'b0;
        cyc  = 1;
        nreq = 0;
        got  = 1'b0;
        while (!got && cyc <= 40) begin
            chk({tag, ".busy"}, bus.busy, 1'b1);
            if (bus.mem_req) begin
                nreq++;
                chk({tag, ".we"}, bus.mem_we, e_we);
                chk({tag, ".addr"}, bus.mem_addr, e_addr);
                chk({tag, ".ben"}, bus.mem_byte_en, e_ben);
                chk({tag, ".wdata"}, bus.mem_wr_data, e_wd);
                if (nreq == ack_at) begin
                    bus.mem_ack     = 1'b1;
                    bus.mem_rd_data = rd;
                end
            end
            if (cyc == poke_at) begin
                bus.req_valid = 1'b1;
                bus.is_store  = 1'b0;
                bus.funct3    = 3'b010;
                bus.addr      = 32'h300;
            end
            if (bus.done) begin
                got = 1'b1;
                chk({tag, ".sb_size"}, sb.size(), 1);
                if (sb.size() > 0) begin
                    r = sb.pop_front();
                    chk({tag, ".load_data"}, bus.load_data, r.ld);
                    chk({tag, ".misaligned"}, bus.misaligned, r.mis);
                    chk({tag, ".fault"}, bus.fault, r.flt);
                end
                chk({tag, ".latency"}, cyc, e_lat);
                chk({tag, ".req_cycles"}, nreq, e_nreq);
            end else begin
                @(negedge clk);
                bus.mem_ack   = 1'b0;
                bus.req_valid = 1'b0;
                cyc++;
            end
        end
        chk({tag, ".timeout"}, got, 1'b1);
        @(negedge clk);
        chk({tag, ".done_pulse"}, bus.done, 1'b0);
        chk({tag, ".busy_after"}, bus.busy, 1'b0);
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.is_store    = 1'b0;
        bus.funct3      = 3'b000;
        bus.addr        = '0;
        bus.store_data  = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rd_data = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", bus.busy, 1'b0);
        chk("rst.req", bus.mem_req, 1'b0);
        chk("rst.we", bus.mem_we, 1'b0);
        chk("rst.done", bus.done, 1'b0);
        chk("rst.flags", {bus.misaligned, bus.fault}, 2'b00);
        chk("rst.addr", bus.mem_addr, 32'h0);
        chk("rst.ben", bus.mem_byte_en, 4'h0);
        chk("rst.wdata", bus.mem_wr_data, 32'h0);
        chk("rst.load", bus.load_data, 32'h0);
        rst = 1'b1;

        //        tag     st  f3      addr        data          ack rd            we   addr        ben      wdata         load          mis  flt lat nreq poke
        run_req("lw",     0, 3'b010, 32'h100,    32'h0,        1, 32'hDEADBEEF, 0, 32'h100,    4'b1111, 32'h0,        32'hDEADBEEF, 0, 0, 2, 1, 0);
        run_req("lb",     0, 3'b000, 32'h103,    32'h0,        1, 32'h80FFFF7F, 0, 32'h100,    4'b1000, 32'h0,        32'hFFFFFF80, 0, 0, 2, 1, 0);
        run_req("lbu",    0, 3'b100, 32'h103,    32'h0,        1, 32'h80FFFF7F, 0, 32'h100,    4'b1000, 32'h0,        32'h00000080, 0, 0, 2, 1, 0);
        run_req("lhu",    0, 3'b101, 32'h102,    32'h0,        1, 32'h80FFFF7F, 0, 32'h100,    4'b1100, 32'h0,        32'h000080FF, 0, 0, 2, 1, 0);
        run_req("lh",     0, 3'b001, 32'h102,    32'h0,        1, 32'h80FFFF7F, 0, 32'h100,    4'b1100, 32'h0,        32'hFFFF80FF, 0, 0, 2, 1, 0);
        run_req("lb1",    0, 3'b000, 32'h201,    32'h0,        2, 32'h1122F344, 0, 32'h200,    4'b0010, 32'h0,        32'hFFFFFFF3, 0, 0, 3, 2, 0);
        run_req("sh",     1, 3'b001, 32'h12,     32'h1234ABCD, 1, 32'h0,        1, 32'h10,     4'b1100, 32'hABCDABCD, 32'h0,        0, 0, 2, 1, 0);
        run_req("sb",     1, 3'b000, 32'h11,     32'h000000A5, 1, 32'hFFFFFFFF, 1, 32'h10,     4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0, 2, 1, 0);
        run_req("sw",     1, 3'b010, 32'h20,     32'hCAFEF00D, 1, 32'h0,        1, 32'h20,     4'b1111, 32'hCAFEF00D, 32'h0,        0, 0, 2, 1, 0);
        run_req("lw_mis", 0, 3'b010, 32'h101,    32'h0,        1, 32'h0,        0, 32'h0,      4'b0000, 32'h0,        32'h0,        1, 0, 1, 0, 0);
        run_req("sh_mis", 1, 3'b001, 32'h13,     32'h5555,     1, 32'h0,        0, 32'h0,      4'b0000, 32'h0,        32'h0,        1, 0, 1, 0, 0);
        run_req("st_ill", 1, 3'b011, 32'h100,    32'h0,        1, 32'h0,        0, 32'h0,      4'b0000, 32'h0,        32'h0,        0, 1, 1, 0, 0);
        run_req("ld_ill", 0, 3'b110, 32'h101,    32'h0,        1, 32'h0,        0, 32'h0,      4'b0000, 32'h0,        32'h0,        0, 1, 1, 0, 0);
        run_req("to",     0, 3'b010, 32'h200,    32'h0,        0, 32'hFFFFFFFF, 0, 32'h200,    4'b1111, 32'h0,        32'h0,        0, 1, 6, 5, 0);
        run_req("to_ack", 0, 3'b010, 32'h200,    32'h0,        5, 32'h11223344, 0, 32'h200,    4'b1111, 32'h0,        32'h11223344, 0, 0, 6, 5, 0);
        run_req("poke",   0, 3'b010, 32'h40,     32'h0,        3, 32'h0BADF00D, 0, 32'h40,     4'b1111, 32'h0,        32'h0BADF00D, 0, 0, 4, 3, 2);
        idle_check("poke", 4, 1'b0);

        // Reset in the middle of an access abandons it silently.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.is_store  = 1'b0;
        bus.funct3    = 3'b010;
        bus.addr      = 32'h400;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_mid.req1", bus.mem_req, 1'b1);
        @(negedge clk);
        chk("rst_mid.req2", bus.mem_req, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid.req", bus.mem_req, 1'b0);
        chk("rst_mid.busy", bus.busy, 1'b0);
        chk("rst_mid.done", bus.done, 1'b0);
        rst = 1'b1;
        idle_check("rst_mid", 3, 1'b0);
        idle_check("spur_ack", 3, 1'b1);

        run_req("post",   0, 3'b000, 32'h500,    32'h0,        1, 32'h0000007F, 0, 32'h500,    4'b0001, 32'h0,        32'h0000007F, 0, 0, 2, 1, 0);
        chk("sb.empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the execute ALU. It takes the ALU sum (effective address) plus store data and access size from the LOAD/STORE instruction. It drives a single-port, word-wide data-memory handshake and returns sign/zero-extended load data, or a completion/fault indication, to writeback. Multi-cycle: the pipeline stalls on busy.

Parameters:
WIDTH, 32, data/address width; must be 32 (byte lanes fixed at 4)
TIMEOUT, 255, max cycles memReq may wait for memAck before a fault; 1..65535
TO_WIDTH, $clog2(TIMEOUT+1), localparam, timeout counter width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-low reset
reqValid  input  1  new access from execute; sampled only in IDLE
isStore  input  1  1=store, 0=load
funct3  input  3  RV32I size/sign field
addr  input  WIDTH  effective address (ALU result)
storeData  input  WIDTH  rs2 value, unshifted
busy  output  1  high when not IDLE; execute/decode stall
memReq  output  1  memory request valid
memWe  output  1  write enable, valid with memReq
memAddr  output  WIDTH  word address {addr[31:2],2'b00}
memByteEn  output  4  byte lanes
memWrData  output  WIDTH  lane-shifted store data
memAck  input  1  memory accepted/completed this cycle
memRdData  input  WIDTH  read word, valid when memAck && !memWe
done  output  1  one-cycle completion pulse
loadData  output  WIDTH  extended load result, valid with done
misaligned  output  1  valid with done; address misaligned
fault  output  1  valid with done; illegal funct3 or timeout

Behaviour:
- Reset (rst==0 at clk edge): state=IDLE. busy, memReq, memWe, done, misaligned, fault=0. memAddr, memByteEn, memWrData, loadData=0. Timeout counter=0. Reset mid-access abandons the access with no done pulse.
- States: IDLE, ACCESS, RESP.
- IDLE: if reqValid, register all request fields and go to ACCESS. If the request is misaligned or illegal, go straight to RESP with the flag set and no memory access.
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. For stores: 000 SB, 001 SH, 010 SW. Any other value sets fault=1.
- Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0. Sets misaligned=1. Illegal funct3 has priority: fault=1, misaligned=0.
- ACCESS: memReq=1, with memWe/memAddr/memByteEn/memWrData constant for the whole state.
  - On memAck: capture memRdData for loads and go to RESP.
  - Timeout counter increments each ACCESS cycle without ack. When it reaches TIMEOUT (ack absent on cycle TIMEOUT+1 of ACCESS), go to RESP with fault=1. memAck on that same cycle wins: normal completion.
- Byte lanes: byte uses 4'b0001<<addr[1:0], with storeData[7:0] replicated on all lanes. Half uses 4'b0011<<addr[1:0], with storeData[15:0] replicated on both halves. Word uses 4'b1111.
- Load extraction: select byte/half by addr[1:0]. Sign-extend for LB/LH; zero-extend for LBU/LHU. On a fault, misaligned access, or store, loadData=0.
- RESP: done=1 for exactly one cycle; memReq=0; flags valid this cycle only. Next state is IDLE. Flags clear when leaving RESP.
- Minimum latency: reqValid at cycle t, memReq at t+1; with ack at t+1, done at t+2. A misaligned/illegal request gives done at t+1.
- busy=1 in ACCESS and RESP. reqValid while busy is ignored, never queued. A new request is accepted in the IDLE cycle immediately after RESP.
- memAck outside ACCESS is ignored.

Test Plan:
- LW at addr 0x100, memAck on first memReq cycle, memRdData=0xDEADBEEF -> memAddr=0x100, memByteEn=1111, done 2 cycles after reqValid, loadData=0xDEADBEEF, flags 0.
- LB at addr 0x103 with rd 0x80FF_FF7F -> byteEn 1000, loadData=0xFFFFFF80. Same with LBU -> 0x00000080. LHU at 0x102 -> 0x000080FF.
- SH at addr 0x12, storeData=0x1234ABCD -> memWe=1, memByteEn=1100, memWrData=0xABCDABCD, done with flags 0.
- LW at 0x101 -> no memReq ever, done 1 cycle after reqValid, misaligned=1, fault=0. Store with funct3=011 -> fault=1, misaligned=0.
- TIMEOUT=4, memAck held low -> memReq high 5 cycles, then done with fault=1, loadData=0. Repeat with ack on the 5th cycle -> normal completion, fault=0.
- Reset low mid-ACCESS -> next cycle memReq=0, busy=0, no done pulse. reqValid pulsed during busy -> ignored, only one done.
